// File: rtl/mac_shift_add_topmodule.sv
// Sequential 4-bit shift-add multiply-accumulate: product = A*B + C, with
// double-dabble BCD conversion and a multiplexed 4-digit seven-segment display.
module mac_shift_add_topmodule #(
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    input  logic [3:0] addend,
    output logic [7:0] product,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] digit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ADD,
        S_CONV,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_start_d;
    logic [7:0]              r_p;
    logic [3:0]              r_a;
    logic [3:0]              r_c;
    logic [3:0]              r_iter;
    logic [7:0]              r_bin;
    logic [11:0]             r_bcd;
    logic [11:0]             r_disp;
    logic [REFRESH_BITS-1:0] r_cnt;

    logic                    w_accept;
    logic [4:0]              w_sum;
    logic [11:0]             w_bcd_adj;
    logic [1:0]              w_sel;
    logic [3:0]              w_nib;
    logic                    w_blank;

    assign w_accept = start & ~r_start_d & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_sum    = {1'b0, r_p[7:4]} + (r_p[0] ? {1'b0, r_a} : 5'd0);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_p       <= '0;
            r_a       <= '0;
            r_c       <= '0;
            r_iter    <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_disp    <= '0;
            product   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_start_d <= start;
            if (w_accept) begin
                r_p     <= {4'b0000, multiplier};
                r_a     <= multiplicand;
                r_c     <= addend;
                r_iter  <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
                r_state <= S_MUL;
            end else begin
                case (r_state)
                    S_MUL: begin
                        r_p    <= {w_sum, r_p[3:1]};
                        r_iter <= r_iter + 4'd1;
                        if (r_iter == 4'd3) begin
                            r_iter  <= '0;
                            r_state <= S_ADD;
                        end
                    end
                    S_ADD: begin
                        r_p     <= r_p + {4'b0000, r_c};
                        r_bin   <= r_p + {4'b0000, r_c};
                        r_bcd   <= '0;
                        r_state <= S_CONV;
                    end
                    S_CONV: begin
                        // Eight shift cycles, then one extra cycle to publish the result,
                        // giving 14 clocks from accept to done.
                        if (r_iter == 4'd8) begin
                            product <= r_p;
                            r_disp  <= r_bcd;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
                            r_iter         <= r_iter + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + REFRESH_BITS'(1);
    end

    assign w_sel = r_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

    always_comb begin
        w_nib   = r_disp[3:0];
        w_blank = 1'b0;
        digit   = 4'b1110;
        case (w_sel)
            2'd0: begin w_nib = r_disp[3:0];  digit = 4'b1110; end
            2'd1: begin w_nib = r_disp[7:4];  digit = 4'b1101; end
            2'd2: begin w_nib = r_disp[11:8]; digit = 4'b1011; end
            default: begin w_blank = 1'b1;    digit = 4'b0111; end
        endcase
    end

    always_comb begin
        seg = 7'b1111111;
        if (!w_blank) begin
            case (w_nib)
                4'd0: seg = 7'b1000000;
                4'd1: seg = 7'b1111001;
                4'd2: seg = 7'b0100100;
                4'd3: seg = 7'b0110000;
                4'd4: seg = 7'b0011001;
                4'd5: seg = 7'b0010010;
                4'd6: seg = 7'b0000010;
                4'd7: seg = 7'b1111000;
                4'd8: seg = 7'b0000000;
                4'd9: seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_shift_add_topmodule.sv
// Directed bench for mac_shift_add_topmodule: latency, results, busy-ignore,
// held start, mid-run reset and display scanning with a short refresh counter.
module tb_mac_shift_add_topmodule;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic [3:0] addend;
    logic [7:0] product;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [3:0] digit;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    mac_shift_add_topmodule #(.REFRESH_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .seg          (seg),
        .digit        (digit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [7:0] exp, input bit inject, input bit hold,
                       input string tag);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        tick();
        chk(busy, 1, {tag, " busy after accept"});
        chk(done, 0, {tag, " done after accept"});
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1 && !hold) start = 1'b0;
            if (inject && k == 5) begin
                start        = 1'b1;
                multiplicand = 4'd15;
                multiplier   = 4'd15;
                addend       = 4'd15;
            end
            if (inject && k == 6) start = 1'b0;
        end
        chk(done, 0, {tag, " done at 13"});
        chk(busy, 1, {tag, " busy at 13"});
        tick();
        chk(done, 1, {tag, " done at 14"});
        chk(busy, 0, {tag, " busy at 14"});
        chk(product, exp, {tag, " product"});
        if (hold) begin
            repeat (3) tick();
            chk(done, 1, {tag, " held start no re-accept done"});
            chk(busy, 0, {tag, " held start no re-accept busy"});
            start = 1'b0;
        end
        if (inject) begin
            repeat (16) tick();
            chk(done, 1, {tag, " done sticky"});
            chk(product, exp, {tag, " product sticky"});
        end
    endtask

    task automatic disp_chk(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input string tag);
        int unsigned guard = 0;
        while (digit !== 4'b0111 && guard < 40) begin tick(); guard++; end
        while (digit !== 4'b1110 && guard < 40) begin tick(); guard++; end
        n_assert++;
        assert (guard < 40)
        else begin
            n_fail++;
            $error("FAIL %s scan sync: observed %0d cycles, expected < 40", tag, guard);
        end
        chk(digit, 4'b1110, {tag, " digit0"});
        chk(seg, s0, {tag, " units"});
        repeat (4) tick();
        chk(digit, 4'b1101, {tag, " digit1"});
        chk(seg, s1, {tag, " tens"});
        repeat (4) tick();
        chk(digit, 4'b1011, {tag, " digit2"});
        chk(seg, s2, {tag, " hundreds"});
        repeat (4) tick();
        chk(digit, 4'b0111, {tag, " digit3"});
        chk(seg, 7'b1111111, {tag, " blank"});
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        #1 rst = 1'b1;
        #1;
        chk(product, 0, "reset product");
        chk(busy, 0, "reset busy");
        chk(done, 0, "reset done");
        chk(digit, 4'b1110, "reset digit");
        chk(seg, 7'b1000000, "reset seg");
        tick();
        tick();
        rst = 1'b0;
        tick();

        run(4'd15, 4'd15, 4'd15, 8'd240, 1'b0, 1'b0, "15x15+15");
        disp_chk(7'b1000000, 7'b0011001, 7'b0100100, "disp240");

        run(4'd2, 4'd3, 4'd1, 8'd7, 1'b0, 1'b0, "2x3+1");
        disp_chk(7'b1111000, 7'b1000000, 7'b1000000, "disp7");

        run(4'd0, 4'd9, 4'd0, 8'd0, 1'b0, 1'b1, "0x9+0");
        tick();
        run(4'd15, 4'd15, 4'd0, 8'd225, 1'b0, 1'b0, "15x15+0");
        run(4'd4, 4'd3, 4'd3, 8'd15, 1'b0, 1'b0, "4x3+3");
        run(4'd5, 4'd5, 4'd2, 8'd27, 1'b1, 1'b0, "busy ignore 5x5+2");

        multiplicand = 4'd9;
        multiplier   = 4'd9;
        addend       = 4'd9;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk(busy, 1, "pre-reset busy");
        rst = 1'b1;
        #1;
        chk(product, 0, "midrun reset product");
        chk(busy, 0, "midrun reset busy");
        chk(done, 0, "midrun reset done");
        chk(digit, 4'b1110, "midrun reset digit");
        chk(seg, 7'b1000000, "midrun reset seg");
        tick();
        rst = 1'b0;
        tick();
        run(4'd4, 4'd3, 4'd3, 8'd15, 1'b0, 1'b0, "post-reset 4x3+3");
        disp_chk(7'b0010010, 7'b1111001, 7'b1000000, "disp15");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_shift_add_topmodule.md
# mac_shift_add_topmodule

Sequential 4-bit shift-add multiply-accumulate unit: computes product = multiplicand × multiplier + addend, the inverse operation of the non-restoring divider. It reconstructs a dividend from quotient, divisor and remainder. Result is presented as an 8-bit binary value and on a multiplexed 4-digit seven-segment display, with the same start/done handshake and display pins as the divider top module. The two blocks together form a divide-then-check loop on the board.

## Interface
- REFRESH_BITS, 16: width of display refresh counter; top 2 bits select digit.
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; rising edge accepted in IDLE or DONE only.
- multiplicand  input  4  unsigned operand A.
- multiplier  input  4  unsigned operand B.
- addend  input  4  unsigned operand C (remainder to add back).
- product  output  8  unsigned A×B+C; valid while done=1.
- busy  output  1  high from accept until result ready.
- done  output  1  high in DONE; sticky until next accepted start or reset.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- digit  output  4  digit enables, active-low; digit[0] = units, digit[3] = leftmost.

## Operation
- Start edge detect: registered start_d; accept = start & ~start_d & (state==IDLE | state==DONE). Held or multi-cycle start is accepted once; start while busy is ignored.
- States: IDLE → MUL → ADD → CONV → DONE; DONE → MUL on accept.
- On accept:
  - P[8:0] ← {5'b0, multiplier}; A, C captured.
  - iter ← 0; busy ← 1; done ← 0.
- MUL, 4 cycles:
  - sum[4:0] = P[7:4] + (P[0] ? A : 0).
  - P ← {1'b0, sum, P[3:1]}.
  - After 4th iteration, go to ADD.
- ADD, 1 cycle: P[7:0] ← P[7:0] + C. Max 225+15 = 240, so no overflow beyond 8 bits.
- CONV, 8 cycles: double-dabble on P[7:0] into hundreds/tens/units BCD.
  - Before each shift, add 3 to any BCD digit ≥5.
  - After 8th shift, go to DONE.
- DONE:
  - product ← P[7:0]; display register ← BCD.
  - done=1, busy=0.
- Display:
  - Free-running refresh counter, REFRESH_BITS wide.
  - sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2].
  - sel 0/1/2 drive units/tens/hundreds; sel 3 = digit[3] enabled with all segments off (blank).
  - Exactly one digit low at a time.
  - Display register updates only on entry to DONE; it holds its value through subsequent computations.
- Segment codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset (async, immediate):
  - state=IDLE; P, product, BCD, display register, counter = 0.
  - busy=0, done=0, start_d=0.
  - digit=4'b1110, seg=1000000 (units shows 0).
- Accept at edge E0: busy=1, done=0 visible after E0.
- E1–E4: MUL iterations. E5: ADD. E6–E13: CONV.
- E14: DONE entered; done=1, busy=0, product valid.
- Latency: 14 clocks from accepting edge to done.
- Operands are sampled only at E0; input changes afterwards have no effect.
- Reset mid-operation: aborts immediately to reset values; no partial product appears.
- Start rising at the same edge as entry to DONE: not accepted (state≠DONE at sample). Acceptance requires a fresh rising edge with state already DONE.
- Start held high from previous request: no re-accept until it falls and rises again.

## Test plan
- Reset, then A=15, B=15, C=15, start high 2 cycles → done 14 clocks after accept; product=240 (8'hF0); display 2,4,0; busy low; exactly one accept.
- A=2, B=3, C=1 (reconstruct 7/2) → product=7; hundreds/tens show 0, units 7 (seg=1111000 when digit[0] low).
- A=0, B=9, C=0 → product=0; A=15, B=15, C=0 → product=225; A=4, B=3, C=3 → product=15.
- Start pulse again at cycle 5 of a busy run, with new operands → ignored; original result delivered at the original time; no second done cycle.
- Assert rst at cycle 7 of a run → outputs at reset values immediately. A new start after release yields the correct full-latency result.
- Step the display with REFRESH_BITS=4 → digit cycles 1110, 1101, 1011, 0111 every 4 clocks; digit[3] phase shows seg=1111111.
